seg_scan_decoder: RTL

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// Multiplexed 7-segment scan decoder: recovers the four displayed BCD digits,
// their binary value, a dark-display indication and protocol/decode errors.
//
// state    | meaning
// ST_BLANK | display dark, waiting for the first valid digit
// ST_SCAN  | collecting digits into per-anode holding registers
// ST_CONV  | mask full; publish the frame unless a violation was seen
module seg_scan_decoder #(
   parameter int STABLE_CNT    = 2,
   parameter int BLANK_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  led_seg,
   input  logic        a1,
   input  logic        a2,
   input  logic        a3,
   input  logic        a4,
   output logic [3:0]  val1,
   output logic [3:0]  val2,
   output logic [3:0]  val3,
   output logic [3:0]  val4,
   output logic [13:0] time_val,
   output logic        frame_valid,
   output logic        blank,
   output logic        seg_error
);

   typedef enum logic [1:0] {ST_BLANK, ST_SCAN, ST_CONV} state_t;

   localparam logic [3:0] STAB_LIM = 4'(STABLE_CNT);
   localparam logic [7:0] IDLE_LIM = 8'(BLANK_TIMEOUT);

   state_t      state;
   logic [10:0] raw, sync1, sync2, prev_key;
   logic [6:0]  seg_s;
   logic [3:0]  an_s;
   logic [3:0]  stab_cnt, stab_nxt;
   logic [7:0]  idle_cnt, idle_nxt;
   logic [3:0]  mask, mask_nxt, acc_bit;
   logic        bad;
   logic [3:0]  hold [4];
   logic [1:0]  idx;
   logic        active, conflict, idle, same;
   logic        accept, acc_ok, err_now, timeout;
   logic        dec_ok;
   logic [3:0]  dec_digit;
   logic [13:0] conv_val;

   // Anodes are inverted before synchronizing so the all-zero reset value reads as idle.
   assign raw   = {led_seg, ~a4, ~a3, ~a2, ~a1};
   assign seg_s = sync2[10:4];
   assign an_s  = sync2[3:0];

   always_comb begin
      idx      = 2'd0;
      active   = 1'b0;
      conflict = 1'b0;
      case (an_s)
         4'b0001: begin idx = 2'd0; active = 1'b1; end
         4'b0010: begin idx = 2'd1; active = 1'b1; end
         4'b0100: begin idx = 2'd2; active = 1'b1; end
         4'b1000: begin idx = 2'd3; active = 1'b1; end
         4'b0000: ;
         default: conflict = 1'b1;
      endcase
      idle = (an_s == 4'b0000);
   end

   always_comb begin
      dec_ok    = 1'b1;
      dec_digit = 4'd0;
      case (seg_s)
         7'b1111110: dec_digit = 4'd0;
         7'b0110000: dec_digit = 4'd1;
         7'b1101101: dec_digit = 4'd2;
         7'b1111001: dec_digit = 4'd3;
         7'b0110011: dec_digit = 4'd4;
         7'b1011011: dec_digit = 4'd5;
         7'b1011111: dec_digit = 4'd6;
         7'b1110000: dec_digit = 4'd7;
         7'b1111111: dec_digit = 4'd8;
         7'b1111011: dec_digit = 4'd9;
         default:    dec_ok    = 1'b0;
      endcase
   end

   always_comb begin
      same = active && (sync2 == prev_key);
      if (!active)
         stab_nxt = 4'd0;
      else if (same)
         stab_nxt = (stab_cnt == STAB_LIM) ? stab_cnt : stab_cnt + 4'd1;
      else
         stab_nxt = 4'd1;
      // Counter parks at the limit, so a held digit is accepted only once.
      accept   = active && (stab_nxt == STAB_LIM) && !(same && (stab_cnt == STAB_LIM));
      acc_ok   = accept && dec_ok;
      err_now  = conflict || (accept && !dec_ok);
      idle_nxt = !idle ? 8'd0 : ((idle_cnt == IDLE_LIM) ? idle_cnt : idle_cnt + 8'd1);
      timeout  = (idle_nxt == IDLE_LIM) && (idle_cnt != IDLE_LIM);
      acc_bit  = accept ? (4'b0001 << idx) : 4'b0000;
      mask_nxt = mask | acc_bit;
      conv_val = {10'd0, hold[0]} * 14'd1000 + {10'd0, hold[1]} * 14'd100
               + {10'd0, hold[2]} * 14'd10   + {10'd0, hold[3]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1       <= '0;
         sync2       <= '0;
         prev_key    <= '0;
         stab_cnt    <= '0;
         idle_cnt    <= '0;
         mask        <= '0;
         bad         <= 1'b0;
         for (int i = 0; i < 4; i++) hold[i] <= '0;
         state       <= ST_BLANK;
         val1        <= '0;
         val2        <= '0;
         val3        <= '0;
         val4        <= '0;
         time_val    <= '0;
         frame_valid <= 1'b0;
         seg_error   <= 1'b0;
         blank       <= 1'b1;
      end else begin
         sync1       <= raw;
         sync2       <= sync1;
         prev_key    <= sync2;
         stab_cnt    <= stab_nxt;
         idle_cnt    <= idle_nxt;
         seg_error   <= err_now;
         frame_valid <= 1'b0;
         if (acc_ok) hold[idx] <= dec_digit;
         if (acc_ok)
            blank <= 1'b0;
         else if (timeout)
            blank <= 1'b1;
         if (timeout) begin
            state <= ST_BLANK;
            mask  <= '0;
            bad   <= 1'b0;
         end else begin
            case (state)
               ST_BLANK: begin
                  if (acc_ok) begin
                     state <= ST_SCAN;
                     mask  <= acc_bit;
                     bad   <= 1'b0;
                  end
               end
               ST_SCAN: begin
                  mask <= mask_nxt;
                  bad  <= bad | err_now;
                  if (&mask_nxt) state <= ST_CONV;
               end
               ST_CONV: begin
                  if (!bad) begin
                     val1        <= hold[0];
                     val2        <= hold[1];
                     val3        <= hold[2];
                     val4        <= hold[3];
                     time_val    <= conv_val;
                     frame_valid <= 1'b1;
                  end
                  // A digit landing in this cycle starts the next frame.
                  mask  <= acc_bit;
                  bad   <= err_now;
                  state <= ST_SCAN;
               end
               default: state <= ST_BLANK;
            endcase
         end
      end
   end

endmodule
